hand_trig_sched: RTL and testbench
==================================

# hand_trig_sched

Scheduler that time-shares one synchronous sine ROM among the second, minute and hour hands of the VGA analog clock. Replaces per-hand sin/cos ROM instances. On each `frame_start` pulse it:
- snapshots the time,
- converts each hand to a quadrant and an in-quadrant index,
- issues six back-to-back ROM reads,
- commits all coefficients atomically.

The pixel-rotation datapath therefore sees stable values for the whole frame. It sits between the time counters and the per-pixel hand renderer, in the 25 MHz VGA clock domain.

## Interface
- `DW`, 20: ROM data width (fixed-point sine magnitude).
- `ROM_LAT`, 1: ROM read latency in cycles (1..3).
- `clk` in 1: VGA pixel clock; single clock domain.
- `reset` in 1: synchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse at start of vertical blanking.
- `hour` in 6, `min` in 6, `sec` in 6: binary time from the clock counters.
- `rom_addr` out 5: registered ROM address, range 0..30.
- `rom_q` in DW: ROM data, valid `ROM_LAT` cycles after its address.
- `sec_sin`, `sec_cos`, `min_sin`, `min_cos`, `hour_sin`, `hour_cos` out DW each: committed magnitudes.
- `sec_quad`, `min_quad`, `hour_quad` out 2 each: committed quadrant (0 = 12-to-3 o'clock, clockwise).
- `coef_valid` out 1: one-cycle pulse when new coefficients are committed.
- `busy` out 1: high from the cycle after an accepted `frame_start` through the COMMIT cycle.
- `overrun` out 1: sticky; cleared only by reset.

## Operation
- Position `p` is measured in 3° steps, range 0..119:
  - sec: `p = 2*sec`.
  - min: `p = 2*min`.
  - hour: `p = 10*(hour mod 12)`.
- Out-of-range inputs (sec/min > 59, hour > 23) are treated as 0 for that hand.
- Quadrant `q = p/30`; index `k = p - 30q`.
- ROM holds `T[a] = sin(3a°)` scaled; `sin = T[k]`, `cos = T[30-k]`. Sign handling belongs to the renderer, based on `quad`.
- FSM states: IDLE, CALC, READ, DRAIN, COMMIT.
  - IDLE → CALC on `frame_start`; time inputs are registered in that cycle.
  - CALC (1 cycle): compute `q` and `k` for all hands into registers.
  - READ (6 cycles): `rom_addr` order is sec-sin, sec-cos, min-sin, min-cos, hour-sin, hour-cos. A 3-bit slot counter is delayed `ROM_LAT` cycles to steer `rom_q` into the shadow registers.
  - DRAIN (`ROM_LAT` cycles): wait for the last return.
  - COMMIT (1 cycle): shadow and quadrants copied to outputs; `coef_valid` = 1; then → IDLE.
- `frame_start` while not IDLE: ignored, no queuing; sets `overrun`.
- `frame_start` in the COMMIT cycle: also ignored.
- `rom_addr` holds its last value when idle.
- Reset, including mid-sequence: state IDLE; all outputs, `rom_addr` and shadow registers 0; `busy`, `coef_valid` and `overrun` 0. A partially read set is never committed.

## Timing
- `frame_start` is sampled in cycle 0.
- CALC occurs in cycle 1.
- `rom_addr` is valid in cycles 2..7.
- Last data returns in cycle `7+ROM_LAT`.
- COMMIT occurs in cycle `8+ROM_LAT`: `coef_valid` is high and the new outputs are visible in that cycle. This is 9 cycles for `ROM_LAT` = 1.
- Earliest accepted next `frame_start` is cycle `9+ROM_LAT`.
- Outputs are constant between COMMIT cycles.

## Configuration
- `HAND_SMOOTH_EN`:
  - Defined: min `p = 2*min + (sec >= 30)`; hour `p = 10*(hour mod 12) + min/6`. Uses the snapshotted values.
  - Undefined: hands jump as in the Operation formulas; the extra adders and divider are absent.

## Structure
- Package `clock_hand_pkg` holds:
  - FSM state enum,
  - hand-slot enum (SEC, MIN, HOUR),
  - constants `STEPS_PER_QUAD` = 30, `ROM_DEPTH` = 31, `READS` = 6.
- Sub-module `hand_angle_calc`: combinational; position to (`q`, `k`, `30-k`). Instantiated three times, registered in CALC.

## Test plan
Bench ROM model: `rom_q = addr + 100`; `ROM_LAT` = 1.
1. Reset held 3 cycles → all outputs 0, `busy` = 0, `overrun` = 0, `rom_addr` = 0.
2. sec=7, min=0, hour=0, one `frame_start` →
   - `rom_addr` 14, 16, 0, 30, 0, 30 in cycles 2..7;
   - cycle 9: `coef_valid` = 1, `sec_sin` = 114, `sec_cos` = 116, `min_cos` = 130, all `quad` = 0.
3. sec=45, min=59, hour=23 (macro undefined) →
   - sec: q = 3, sin = 100, cos = 130;
   - min: p = 118, q = 3, k = 28, sin = 128, cos = 102;
   - hour: p = 110, q = 3, k = 20, sin = 120, cos = 110.
4. hour=15, min=36, sec=0 →
   - with `HAND_SMOOTH_EN`: hour p = 36, quad = 1, sin = 106, cos = 124;
   - without: hour p = 30, quad = 1, sin = 100, cos = 130.
5. Second `frame_start` at cycle 4 → exactly one `coef_valid` (cycle 9), `overrun` = 1 and stays 1.
6. Reset asserted at cycle 5 of a sequence, then sec=60 with `frame_start` → no commit from the aborted sequence; new commit has sec sin = 100, cos = 130, quad = 0.

Source files
------------

// File: rtl/hand_trig_sched_pkg.sv
// Shared types and constants for the clock-hand sine ROM scheduler.
// The optional HAND_SMOOTH_EN macro (used by the top) does not change anything here.
package clock_hand_pkg;

    localparam int STEPS_PER_QUAD = 30;
    localparam int ROM_DEPTH      = 31;
    localparam int READS          = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CALC   = 3'd1,
        ST_READ   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        HAND_SEC  = 2'd0,
        HAND_MIN  = 2'd1,
        HAND_HOUR = 2'd2
    } hand_t;

endpackage

// File: rtl/hand_trig_sched_if.sv
// Read port of the shared synchronous sine ROM.
// Protocol: master drives rom_addr every cycle; slave returns rom_q a fixed
// ROM_LAT cycles later. There is no valid/ready pair and no back-pressure.
interface hand_trig_sched_if #(
    parameter int DW = 20
);
    logic [4:0]    rom_addr;
    logic [DW-1:0] rom_q;

    modport master (output rom_addr, input rom_q);
    modport slave  (input rom_addr, output rom_q);
endinterface

// File: rtl/hand_trig_sched_angle_calc.sv
// Splits a hand position (3-degree steps, 0..119) into quadrant, index and
// complementary index 30-k used to fetch the cosine from the sine table.
module hand_angle_calc
    import clock_hand_pkg::*;
(
    input  logic [6:0] pos,
    output logic [1:0] quad,
    output logic [4:0] idx,
    output logic [4:0] idx_c
);

    logic [6:0] base;

    always_comb begin
        quad = 2'd0;
        base = 7'd0;
        if (pos >= 7'(3 * STEPS_PER_QUAD)) begin
            quad = 2'd3;
            base = 7'(3 * STEPS_PER_QUAD);
        end else if (pos >= 7'(2 * STEPS_PER_QUAD)) begin
            quad = 2'd2;
            base = 7'(2 * STEPS_PER_QUAD);
        end else if (pos >= 7'(STEPS_PER_QUAD)) begin
            quad = 2'd1;
            base = 7'(STEPS_PER_QUAD);
        end
        idx   = 5'(pos - base);
        idx_c = 5'(ROM_DEPTH - 1) - idx;
    end

endmodule

// File: rtl/hand_trig_sched.sv
// Time-shares one sine ROM among the sec/min/hour hands once per frame and
// commits all coefficients together. Define HAND_SMOOTH_EN for creeping min/hour hands.
module hand_trig_sched
    import clock_hand_pkg::*;
#(
    parameter int DW      = 20,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic [5:0]        hour,
    input  logic [5:0]        min,
    input  logic [5:0]        sec,
    hand_trig_sched_if.master rom,
    output logic [DW-1:0]     sec_sin,
    output logic [DW-1:0]     sec_cos,
    output logic [DW-1:0]     min_sin,
    output logic [DW-1:0]     min_cos,
    output logic [DW-1:0]     hour_sin,
    output logic [DW-1:0]     hour_cos,
    output logic [1:0]        sec_quad,
    output logic [1:0]        min_quad,
    output logic [1:0]        hour_quad,
    output logic              coef_valid,
    output logic              busy,
    output logic              overrun,
    output state_t            dbg_state
);

    state_t        state;
    logic [5:0]    sec_s, min_s, hour_s;
    logic [5:0]    hour12;
    logic [6:0]    pos_sec, pos_min, pos_hour;
    logic [1:0]    q_c  [3];
    logic [4:0]    k_c  [3];
    logic [4:0]    kc_c [3];
    logic [1:0]    q_r  [3];
    logic [4:0]    k_r  [3];
    logic [4:0]    kc_r [3];
    logic [2:0]    slot;
    logic [4:0]    next_addr;
    logic [1:0]    drain_cnt;
    logic          pipe_v [ROM_LAT];
    logic [2:0]    pipe_s [ROM_LAT];
    logic [DW-1:0] shadow     [READS];
    logic [DW-1:0] shadow_nxt [READS];

    assign dbg_state = state;

    always_comb begin
        hour12  = (hour_s >= 6'd12) ? hour_s - 6'd12 : hour_s;
        pos_sec = {sec_s, 1'b0};
`ifdef HAND_SMOOTH_EN
        pos_min  = {min_s, 1'b0} + {6'd0, (sec_s >= 6'd30)};
        pos_hour = 7'({1'b0, hour12} * 7'd10) + 7'(min_s / 6'd6);
`else
        pos_min  = {min_s, 1'b0};
        pos_hour = 7'({1'b0, hour12} * 7'd10);
`endif
    end

    hand_angle_calc u_calc_sec (
        .pos(pos_sec), .quad(q_c[HAND_SEC]), .idx(k_c[HAND_SEC]), .idx_c(kc_c[HAND_SEC])
    );
    hand_angle_calc u_calc_min (
        .pos(pos_min), .quad(q_c[HAND_MIN]), .idx(k_c[HAND_MIN]), .idx_c(kc_c[HAND_MIN])
    );
    hand_angle_calc u_calc_hour (
        .pos(pos_hour), .quad(q_c[HAND_HOUR]), .idx(k_c[HAND_HOUR]), .idx_c(kc_c[HAND_HOUR])
    );

    // Address for the slot after the current one (sin, cos per hand in order).
    always_comb begin
        next_addr = k_r[HAND_SEC];
        case (slot)
            3'd0:    next_addr = kc_r[HAND_SEC];
            3'd1:    next_addr = k_r[HAND_MIN];
            3'd2:    next_addr = kc_r[HAND_MIN];
            3'd3:    next_addr = k_r[HAND_HOUR];
            3'd4:    next_addr = kc_r[HAND_HOUR];
            default: next_addr = k_r[HAND_SEC];
        endcase
    end

    // Returning ROM data lands in the shadow slot whose address left ROM_LAT cycles ago.
    always_comb begin
        for (int i = 0; i < READS; i++) begin
            shadow_nxt[i] = shadow[i];
            if (pipe_v[ROM_LAT-1] && pipe_s[ROM_LAT-1] == 3'(i)) begin
                shadow_nxt[i] = rom.rom_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            sec_s        <= '0;
            min_s        <= '0;
            hour_s       <= '0;
            slot         <= '0;
            drain_cnt    <= '0;
            rom.rom_addr <= '0;
            sec_sin      <= '0;
            sec_cos      <= '0;
            min_sin      <= '0;
            min_cos      <= '0;
            hour_sin     <= '0;
            hour_cos     <= '0;
            sec_quad     <= '0;
            min_quad     <= '0;
            hour_quad    <= '0;
            coef_valid   <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                q_r[i]  <= '0;
                k_r[i]  <= '0;
                kc_r[i] <= '0;
            end
            for (int i = 0; i < ROM_LAT; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_s[i] <= '0;
            end
            for (int i = 0; i < READS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            coef_valid <= 1'b0;
            pipe_v[0]  <= (state == ST_READ);
            pipe_s[0]  <= slot;
            for (int i = 1; i < ROM_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_s[i] <= pipe_s[i-1];
            end
            shadow <= shadow_nxt;
            if (frame_start && state != ST_IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        sec_s  <= (sec  > 6'd59) ? 6'd0 : sec;
                        min_s  <= (min  > 6'd59) ? 6'd0 : min;
                        hour_s <= (hour > 6'd23) ? 6'd0 : hour;
                        busy   <= 1'b1;
                        state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    for (int i = 0; i < 3; i++) begin
                        q_r[i]  <= q_c[i];
                        k_r[i]  <= k_c[i];
                        kc_r[i] <= kc_c[i];
                    end
                    rom.rom_addr <= k_c[HAND_SEC];
                    slot         <= '0;
                    state        <= ST_READ;
                end
                ST_READ: begin
                    if (slot == 3'(READS - 1)) begin
                        drain_cnt <= '0;
                        state     <= ST_DRAIN;
                    end else begin
                        slot         <= slot + 3'd1;
                        rom.rom_addr <= next_addr;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == 2'(ROM_LAT - 1)) begin
                        // The last word arrives this cycle, so take it from shadow_nxt.
                        sec_sin    <= shadow_nxt[0];
                        sec_cos    <= shadow_nxt[1];
                        min_sin    <= shadow_nxt[2];
                        min_cos    <= shadow_nxt[3];
                        hour_sin   <= shadow_nxt[4];
                        hour_cos   <= shadow_nxt[5];
                        sec_quad   <= q_r[HAND_SEC];
                        min_quad   <= q_r[HAND_MIN];
                        hour_quad  <= q_r[HAND_HOUR];
                        coef_valid <= 1'b1;
                        state      <= ST_COMMIT;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                ST_COMMIT: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hand_trig_sched.sv
// Self-checking bench for hand_trig_sched: ROM model rom_q = addr + 100, ROM_LAT = 1.
// Expected coefficient sets are queued when a frame is started and popped on coef_valid.
module tb_hand_trig_sched;
    import clock_hand_pkg::*;

    localparam int DW      = 20;
    localparam int ROM_LAT = 1;
    localparam int EW      = 6 * DW + 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          frame_start = 1'b0;
    logic [5:0]    hour = '0, min = '0, sec = '0;
    logic [DW-1:0] sec_sin, sec_cos, min_sin, min_cos, hour_sin, hour_cos;
    logic [1:0]    sec_quad, min_quad, hour_quad;
    logic          coef_valid, busy, overrun;
    state_t        dbg_state;

    logic [EW-1:0] exp_q[$];
    int            n_vec = 0;
    int            n_miss = 0;
    int            n_commits = 0;

    hand_trig_sched_if #(.DW(DW)) rom_bus ();

    hand_trig_sched #(.DW(DW), .ROM_LAT(ROM_LAT)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .hour(hour), .min(min), .sec(sec), .rom(rom_bus.master),
        .sec_sin(sec_sin), .sec_cos(sec_cos), .min_sin(min_sin), .min_cos(min_cos),
        .hour_sin(hour_sin), .hour_cos(hour_cos),
        .sec_quad(sec_quad), .min_quad(min_quad), .hour_quad(hour_quad),
        .coef_valid(coef_valid), .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
    );

    // ---------------- clock / ROM model ----------------
    always #20 clk = ~clk;

    always @(posedge clk) rom_bus.rom_q <= DW'(rom_bus.rom_addr) + DW'(100);

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] model(input logic [5:0] h, input logic [5:0] m,
                                            input logic [5:0] s);
        int            hs, ms, ss;
        int            p [3];
        logic [DW-1:0] v [6];
        logic [1:0]    q [3];
        ss = (s > 59) ? 0 : int'(s);
        ms = (m > 59) ? 0 : int'(m);
        hs = (h > 23) ? 0 : int'(h);
        p[0] = 2 * ss;
`ifdef HAND_SMOOTH_EN
        p[1] = 2 * ms + ((ss >= 30) ? 1 : 0);
        p[2] = 10 * (hs % 12) + ms / 6;
`else
        p[1] = 2 * ms;
        p[2] = 10 * (hs % 12);
`endif
        for (int i = 0; i < 3; i++) begin
            q[i]       = 2'(p[i] / 30);
            v[2*i]     = DW'(p[i] % 30 + 100);
            v[2*i + 1] = DW'(30 - p[i] % 30 + 100);
        end
        return {v[0], v[1], v[2], v[3], v[4], v[5], q[0], q[1], q[2]};
    endfunction

    // Scoreboard: every commit must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (reset && coef_valid) begin
            n_commits++;
            if (exp_q.size() == 0) begin
                check("spurious_commit", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sec_sin",   sec_sin,   e[6*DW+5 -: DW]);
                check("sec_cos",   sec_cos,   e[5*DW+5 -: DW]);
                check("min_sin",   min_sin,   e[4*DW+5 -: DW]);
                check("min_cos",   min_cos,   e[3*DW+5 -: DW]);
                check("hour_sin",  hour_sin,  e[2*DW+5 -: DW]);
                check("hour_cos",  hour_cos,  e[DW+5 -: DW]);
                check("sec_quad",  sec_quad,  e[5:4]);
                check("min_quad",  min_quad,  e[3:2]);
                check("hour_quad", hour_quad, e[1:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Returns #1 into cycle 1 (frame_start was high during cycle 0).
    task automatic pulse_frame(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
        @(posedge clk);
        #1;
        hour = h;
        min  = m;
        sec  = s;
        frame_start = 1'b1;
        exp_q.push_back(model(h, m, s));
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        hour = 6'($urandom_range(0, 63));
        min  = 6'($urandom_range(0, 63));
        sec  = 6'($urandom_range(0, 63));
    endtask

    task automatic wait_commit(input int n_before);
        int t = 0;
        while (n_commits == n_before && t < 30) begin
            @(negedge clk);
            t++;
        end
        check("commit_seen", (n_commits != n_before), 1);
        t = 0;
        while (dbg_state != ST_IDLE && t < 30) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic run_frame(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
        int n0 = n_commits;
        pulse_frame(h, m, s);
        wait_commit(n0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_coefs"}, {sec_sin, sec_cos, min_sin, min_cos, hour_sin, hour_cos}, 0);
        check({tag, "_quads"}, {sec_quad, min_quad, hour_quad}, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_cvalid"}, coef_valid, 0);
        check({tag, "_addr"}, rom_bus.rom_addr, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [4:0] addr_exp [6];
        int         n0;
        addr_exp = '{5'd14, 5'd16, 5'd0, 5'd30, 5'd0, 5'd30};

        // 1: reset held three cycles
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_cleared("reset");

        // 2: cycle-accurate sequence for sec=7
        pulse_frame(6'd0, 6'd0, 6'd7);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 7) check("t2_addr", rom_bus.rom_addr, addr_exp[c-2]);
            check("t2_busy", busy, (c <= 9));
            check("t2_cvalid", coef_valid, (c == 9));
            if (c == 9) begin
                check("t2_sec_sin", sec_sin, 114);
                check("t2_sec_cos", sec_cos, 116);
                check("t2_min_cos", min_cos, 130);
            end
        end

        // 3 and 4: quadrant boundaries and hour wrap
        run_frame(6'd23, 6'd59, 6'd45);
        run_frame(6'd15, 6'd36, 6'd0);
        check("t4_hour_quad", hour_quad, 1);
`ifdef HAND_SMOOTH_EN
        check("t4_hour_sin", hour_sin, 106);
        check("t4_hour_cos", hour_cos, 124);
`else
        check("t4_hour_sin", hour_sin, 100);
        check("t4_hour_cos", hour_cos, 130);
`endif

        // 5: frame_start at cycle 4 is dropped and flags overrun
        n0 = n_commits;
        pulse_frame(6'd3, 6'd20, 6'd10);
        repeat (3) @(posedge clk);
        #1;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        for (int c = 5; c <= 14; c++) begin
            @(negedge clk);
            check("t5_cvalid", coef_valid, (c == 9));
        end
        check("t5_commits", n_commits - n0, 1);
        check("t5_overrun", overrun, 1);

        // frame_start during the COMMIT cycle is also dropped
        n0 = n_commits;
        pulse_frame(6'd8, 6'd31, 6'd59);
        repeat (8) @(posedge clk);
        #1;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        repeat (14) @(negedge clk);
        check("t5_commit_drop", n_commits - n0, 1);
        check("t5_sticky", overrun, 1);

        // random frames, including out-of-range times
        for (int i = 0; i < 8; i++) begin
            run_frame(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                      6'($urandom_range(0, 63)));
        end
        check("rand_sticky", overrun, 1);

        // 6: reset in cycle 5 aborts the sequence
        pulse_frame(6'd11, 6'd44, 6'd17);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_cleared("t6");
        n0 = n_commits;
        repeat (15) @(negedge clk);
        check("t6_no_commit", n_commits - n0, 0);
        run_frame(6'd0, 6'd0, 6'd60);
        check("t6_sec_sin", sec_sin, 100);
        check("t6_sec_cos", sec_cos, 130);
        check("t6_sec_quad", sec_quad, 0);

        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
